// File: rtl/tlc_pkg.sv
// Shared definitions for the vehicle light controller and the pedestrian crossing.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WALK_TIME       = 6;
  localparam int DEF_FLASH_TIME      = 3;
  localparam int DEF_FLASH_HALF      = 1;
  localparam int DEF_CNT_W           = 4;

  typedef enum logic [1:0] {
    PED_IDLE,
    PED_WALK,
    PED_FLASH,
    PED_FAULT
  } ped_state_e;

  // Lamp vector is {red, yellow, green}.
  function automatic logic lamps_onehot(input logic [2:0] lamps);
    return (lamps == LAMP_RED) || (lamps == LAMP_YELLOW) || (lamps == LAMP_GREEN);
  endfunction

endpackage

// File: rtl/ped_btn_debounce.sv
// Pedestrian button: two-flop synchroniser, stability debounce and a one-cycle
// pulse on each debounced rising edge.
module ped_btn_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          btn_db;
  logic          btn_db_q;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The streak restarts whenever the synced sample agrees with btn_db again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db     <= 1'b0;
      btn_db_q   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (sync2 != btn_db) begin
        if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db     <= sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DW'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle lamps: request latch,
// WALK/FLASH sequencing inside vehicle red, countdown and sticky lamp fault.
module ped_crossing_ctrl
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WALK_TIME       = DEF_WALK_TIME,
  parameter int FLASH_TIME      = DEF_FLASH_TIME,
  parameter int FLASH_HALF      = DEF_FLASH_HALF,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             red_in,
  input  logic             yellow_in,
  input  logic             green_in,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             fault
);

  ped_state_e       state;
  logic             btn_rise;
  logic             red_q;
  logic             bad_q;
  logic             onehot_bad;
  logic             red_rise;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] half_cnt;

  ped_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .btn_rise(btn_rise)
  );

  assign onehot_bad = !lamps_onehot({red_in, yellow_in, green_in});
  assign red_rise   = red_in & ~red_q;

  // red_q resets high so a red phase already in progress at reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q <= 1'b1;
      bad_q <= 1'b0;
    end else begin
      red_q <= red_in;
      bad_q <= onehot_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PED_IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= '0;
      fault       <= 1'b0;
      phase_cnt   <= '0;
      half_cnt    <= '0;
    end else if (state != PED_FAULT && onehot_bad && bad_q) begin
      state       <= PED_FAULT;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= '0;
      fault       <= 1'b1;
    end else begin
      case (state)
        PED_IDLE: begin
          if (red_rise && (req_pending || btn_rise)) begin
            state       <= PED_WALK;
            walk        <= 1'b1;
            dont_walk   <= 1'b0;
            req_pending <= 1'b0;
            countdown   <= CNT_W'(WALK_TIME + FLASH_TIME);
            phase_cnt   <= '0;
          end else if (btn_rise) begin
            req_pending <= 1'b1;
          end
        end
        PED_WALK, PED_FLASH: begin
          if (btn_rise) begin
            req_pending <= 1'b1;
          end
          if (!red_in) begin
            state     <= PED_IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= '0;
          end else if (state == PED_WALK) begin
            countdown <= countdown - CNT_W'(1);
            if (phase_cnt == CNT_W'(WALK_TIME - 1)) begin
              state     <= PED_FLASH;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              phase_cnt <= '0;
              half_cnt  <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end else if (phase_cnt == CNT_W'(FLASH_TIME - 1)) begin
            state     <= PED_IDLE;
            dont_walk <= 1'b1;
            countdown <= '0;
          end else begin
            countdown <= countdown - CNT_W'(1);
            phase_cnt <= phase_cnt + CNT_W'(1);
            if (half_cnt == CNT_W'(FLASH_HALF - 1)) begin
              dont_walk <= ~dont_walk;
              half_cnt  <= '0;
            end else begin
              half_cnt <= half_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          req_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench: directed scenarios plus randomized light cycles and button
// activity, compared every cycle against a countdown-based reference model.
module tb_ped_crossing_ctrl;

  localparam int DB = 4;
  localparam int WT = 6;
  localparam int FT = 3;
  localparam int FH = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn;
  logic          red_in;
  logic          yellow_in;
  logic          green_in;
  logic          walk;
  logic          dont_walk;
  logic          req_pending;
  logic [CW-1:0] countdown;
  logic          fault;

  int tests_run    = 0;
  int tests_failed = 0;
  bit btn_lvl      = 1'b0;

  // Reference model state: remaining walk+flash cycles (0 means idle).
  bit sync_q[$];
  bit m_db, m_db_last, m_red_prev, m_bad_prev, m_req, m_fault;
  int m_streak, m_rem;

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .WALK_TIME      (WT),
    .FLASH_TIME     (FT),
    .FLASH_HALF     (FH),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .red_in     (red_in),
    .yellow_in  (yellow_in),
    .green_in   (green_in),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    sync_q     = {1'b0, 1'b0};
    m_db       = 0;
    m_db_last  = 0;
    m_streak   = 0;
    m_red_prev = 1;
    m_bad_prev = 0;
    m_req      = 0;
    m_fault    = 0;
    m_rem      = 0;
  endtask

  task automatic modelStep();
    bit rise, red_rise, bad, synced;
    rise     = m_db && !m_db_last;
    red_rise = red_in && !m_red_prev;
    bad      = (int'(red_in) + int'(yellow_in) + int'(green_in)) != 1;
    if (m_fault) begin
      m_req = 0;
    end else if (bad && m_bad_prev) begin
      m_fault = 1;
      m_rem   = 0;
      m_req   = 0;
    end else if (m_rem == 0) begin
      if (red_rise && (m_req || rise)) begin
        m_rem = WT + FT;
        m_req = 0;
      end else if (rise) begin
        m_req = 1;
      end
    end else begin
      if (rise) m_req = 1;
      m_rem = red_in ? m_rem - 1 : 0;
    end
    synced = sync_q.pop_front();
    sync_q.push_back(btn);
    m_db_last = m_db;
    if (synced != m_db) begin
      m_streak++;
      if (m_streak == DB) begin
        m_db     = synced;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_red_prev = red_in;
    m_bad_prev = bad;
  endtask

  task automatic checkAll(input string tag);
    bit exp_dw;
    if (m_rem == 0)      exp_dw = 1;
    else if (m_rem > FT) exp_dw = 0;
    else                 exp_dw = (((FT - m_rem) / FH) % 2) == 0;
    checkOutput({tag, "_walk"}, walk, (m_rem > FT) ? 1 : 0);
    checkOutput({tag, "_dw"}, dont_walk, exp_dw);
    checkOutput({tag, "_cd"}, countdown, m_rem);
    checkOutput({tag, "_req"}, req_pending, m_req);
    checkOutput({tag, "_fault"}, fault, m_fault);
  endtask

  task automatic applyStimulus(input bit b, input bit r, input bit y, input bit g);
    btn       = b;
    red_in    = r;
    yellow_in = y;
    green_in  = g;
    @(posedge clk);
    modelStep();
    #1;
    checkAll("cyc");
  endtask

  // mode: 0 released, 1 held, 2 one-cycle bounce, 3 random hold lengths
  task automatic phase(input bit r, input bit y, input bit g, input int len, input int mode);
    bit b;
    for (int i = 0; i < len; i++) begin
      case (mode)
        1:       b = 1;
        2:       b = i[0];
        3: begin
          if ($urandom_range(0, 7) == 0) btn_lvl = ~btn_lvl;
          b = btn_lvl;
        end
        default: b = 0;
      endcase
      applyStimulus(b, r, y, g);
    end
  endtask

  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #2;
    modelReset();
    checkAll(tag);
    checkOutput({tag, "_walk_c"}, walk, 0);
    checkOutput({tag, "_dw_c"}, dont_walk, 1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; btn = 0; red_in = 0; yellow_in = 0; green_in = 1;
    modelReset();
    #12;
    checkAll("rst0");
    rst_n = 1'b1;

    // Press in green, serve at red rise, full walk and flash sequence.
    phase(0, 0, 1, 3, 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 0, 0, 1);
      if (i == DB + 2) checkOutput("t1_req_early", req_pending, 0);
      if (i == DB + 3) checkOutput("t1_req_lat", req_pending, 1);
    end
    phase(0, 0, 1, 4, 0);
    phase(0, 1, 0, 2, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("t1_walk", walk, (i < WT) ? 1 : 0);
      checkOutput("t1_cd", countdown, (i < WT + FT) ? WT + FT - i : 0);
      checkOutput("t1_dw", dont_walk, (i < WT) ? 0 : (i < WT + FT) ? ((i - WT) % 2 == 0) : 1);
      if (i == 0) checkOutput("t1_req_clr", req_pending, 0);
    end

    // Two light cycles with no press.
    for (int k = 0; k < 2; k++) begin
      phase(0, 0, 1, 8, 0);
      phase(0, 1, 0, 2, 0);
      phase(1, 0, 0, 12, 0);
    end

    // One-cycle bounces never latch a request.
    phase(0, 0, 1, 20, 2);
    phase(0, 0, 1, 6, 0);
    checkOutput("t3_req", req_pending, 0);
    phase(0, 1, 0, 2, 0);
    phase(1, 0, 0, 12, 0);

    // Red drops during the third WALK cycle.
    phase(0, 0, 1, 10, 1);
    phase(0, 0, 1, 2, 0);
    phase(0, 1, 0, 2, 0);
    phase(1, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t4_walk", walk, 0);
    checkOutput("t4_dw", dont_walk, 1);
    checkOutput("t4_cd", countdown, 0);
    phase(0, 0, 1, 8, 0);

    // Lamp fault: one glitch cycle ignored, two cycles latch until reset.
    applyStimulus(0, 1, 0, 1);
    phase(0, 0, 1, 3, 0);
    checkOutput("t5_glitch", fault, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("t5_fault", fault, 1);
    checkOutput("t5_walk", walk, 0);
    checkOutput("t5_dw", dont_walk, 1);
    phase(0, 0, 1, 10, 1);
    phase(0, 1, 0, 2, 0);
    phase(1, 0, 0, 12, 0);
    checkOutput("t5_held", fault, 1);
    checkOutput("t5_req", req_pending, 0);
    pulseReset("t5_rst");
    checkOutput("t5_fault_clr", fault, 0);

    // Reset mid-FLASH; the red phase in progress never grants WALK.
    phase(0, 0, 1, 4, 0);
    phase(0, 0, 1, 10, 1);
    phase(0, 0, 1, 2, 0);
    phase(0, 1, 0, 2, 0);
    phase(1, 0, 0, WT + 1, 0);
    checkOutput("t6_in_flash", countdown, FT);
    pulseReset("t6_rst");
    checkOutput("t6_cd_rst", countdown, 0);
    phase(1, 0, 0, 10, 1);
    phase(1, 0, 0, 5, 0);
    checkOutput("t6_no_walk", walk, 0);
    checkOutput("t6_pending", req_pending, 1);
    phase(0, 0, 1, 6, 0);
    phase(0, 1, 0, 2, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t6_walk", walk, 1);
    checkOutput("t6_cd", countdown, WT + FT);
    phase(1, 0, 0, 12, 0);

    // Randomized light cycles with random button hold lengths.
    for (int k = 0; k < 25; k++) begin
      phase(0, 0, 1, $urandom_range(4, 12), 3);
      phase(0, 1, 0, $urandom_range(2, 3), 3);
      phase(1, 0, 0, $urandom_range(10, 14), 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
